branch_control: RTL and testbench
=================================

Name: branch_control

Overview:
- Branch comparator and branch-decision unit for the RV32I execute stage.
- Combinationally compares rs1/rs2 and produces equal, signed-less-than and unsigned-less-than flags.
- Decodes opcode/funct3 to a take-branch decision.
- Also provides a registered copy of the decision for the fetch/PC-select stage.

Parameters:
- XLEN, 32, operand width in bits.

Ports:
- clk_i  input  1  clock; all registers update on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- opcode_i  input  7  instruction opcode field.
- funct3_i  input  3  instruction funct3 field.
- rs1_i  input  XLEN  operand A.
- rs2_i  input  XLEN  operand B.
- breq_o  output  1  rs1_i == rs2_i (combinational).
- brlt_o  output  1  signed rs1_i < rs2_i (combinational).
- brltu_o  output  1  unsigned rs1_i < rs2_i (combinational).
- is_branch_o  output  1  opcode_i == 7'b1100011 (combinational).
- taken_o  output  1  branch decision (combinational).
- taken_q_o  output  1  taken_o registered one cycle.
- illegal_q_o  output  1  registered flag: branch opcode with reserved funct3.

Behaviour:
- Reset: taken_q_o=0 and illegal_q_o=0, asynchronously on rst_ni low, held while low. Combinational outputs are unaffected by reset.
- breq_o, brlt_o and brltu_o depend only on rs1_i/rs2_i. They are valid in the same cycle, with zero clock latency and independent of opcode_i/funct3_i.
- brlt_o uses two's-complement comparison: 0x80000000 < 0; 0xFFFFFFFF (-1) < 0; 0 is not < -1.
- brltu_o uses unsigned comparison: 0 < 0xFFFFFFFF; 0x80000000 is not < 0.
- Equal operands give breq_o=1, brlt_o=0, brltu_o=0.
- taken_o=0 whenever is_branch_o=0. When is_branch_o=1, funct3 selects the condition:
  - 000 BEQ: breq_o
  - 001 BNE: !breq_o
  - 100 BLT: brlt_o
  - 101 BGE: !brlt_o
  - 110 BLTU: brltu_o
  - 111 BGEU: !brltu_o
  - 010/011 (reserved): taken_o=0, and the condition is flagged illegal.
- Rising edge with rst_ni high: taken_q_o<=taken_o; illegal_q_o<=(is_branch_o && funct3_i in {010,011}).
- Reset asserted mid-operation clears the registers immediately. The first edge after release captures current inputs.
- No X propagation is allowed on outputs for known inputs. All comparisons are full XLEN width with no truncation.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds outputs branch_cnt_o (32) and taken_cnt_o (32).
  - Both reset to 0 asynchronously.
  - Each rising edge: branch_cnt_o increments when is_branch_o=1; taken_cnt_o increments when taken_o=1.
  - Both wrap modulo 2^32 (0xFFFFFFFF+1 -> 0).
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Comparator sweep, opcode=0, funct3=0:
  - (5,5), (0,0), (-1,-1) -> breq=1, brlt=0.
  - (1,2), (10,100), (-5,3), (-10,-2), (-1,0), (0x80000000,0) -> breq=0, brlt=1.
  - (50,10), (3,-5), (-1,-20), (0,0x80000000), (0,-1) -> breq=0, brlt=0.
  - Checked after 1 ns settle, with is_branch_o=0 and taken_o=0 throughout.
- Unsigned check: (0,0xFFFFFFFF) -> brltu=1, brlt=0; (0x80000000,1) -> brltu=0, brlt=1.
- Decision table, opcode=1100011, rs1=-1, rs2=0:
  - funct3 000 -> 0; 001 -> 1; 100 -> 1; 101 -> 0; 110 -> 0; 111 -> 1; 010 -> 0.
  - After the 010 case, the next edge gives illegal_q_o=1.
- Register timing: taken_o toggles 0->1 before an edge -> taken_q_o=1 after that edge, not before.
- Reset: drive taken_o=1, clock, then pull rst_ni low mid-cycle -> taken_q_o and illegal_q_o go 0 without waiting for an edge. Release -> next edge recaptures.
- BRANCH_STATS_EN:
  - 5 cycles of BEQ with equal operands, then 3 cycles of BNE with equal operands -> branch_cnt_o=8, taken_cnt_o=5.
  - Force counter to 0xFFFFFFFF -> next increment gives 0.

Source files
------------

// File: rtl/branch_control.sv
// RV32I branch comparator and take-branch decision with a registered copy for PC select.
// Optional BRANCH_STATS_EN adds free-running branch and taken counters.
module branch_control #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            breq_o,
  output logic            brlt_o,
  output logic            brltu_o,
  output logic            is_branch_o,
  output logic            taken_o,
  output logic            taken_q_o,
  output logic            illegal_q_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     taken_cnt_o
`endif
);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_RSV0 = 3'b010;
  localparam logic [2:0] F3_RSV1 = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  logic illegal;

  assign breq_o      = (rs1_i == rs2_i);
  assign brlt_o      = ($signed(rs1_i) < $signed(rs2_i));
  assign brltu_o     = (rs1_i < rs2_i);
  assign is_branch_o = (opcode_i == OPC_BRANCH);

  always_comb begin
    taken_o = 1'b0;
    illegal = 1'b0;
    if (is_branch_o) begin
      case (funct3_i)
        F3_BEQ:  taken_o = breq_o;
        F3_BNE:  taken_o = !breq_o;
        F3_BLT:  taken_o = brlt_o;
        F3_BGE:  taken_o = !brlt_o;
        F3_BLTU: taken_o = brltu_o;
        F3_BGEU: taken_o = !brltu_o;
        F3_RSV0,
        F3_RSV1: illegal = 1'b1;
        default: taken_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      taken_q_o   <= 1'b0;
      illegal_q_o <= 1'b0;
    end else begin
      taken_q_o   <= taken_o;
      illegal_q_o <= illegal;
    end
  end

`ifdef BRANCH_STATS_EN
  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt_o <= 32'd0;
      taken_cnt_o  <= 32'd0;
    end else begin
      if (is_branch_o) branch_cnt_o <= branch_cnt_o + 32'd1;
      if (taken_o)     taken_cnt_o  <= taken_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_control.sv
// Self-checking bench for branch_control: directed test-plan cases plus randomized
// stimulus against an arithmetic reference model.
module tb_branch_control;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        breq_o, brlt_o, brltu_o, is_branch_o, taken_o, taken_q_o, illegal_q_o;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt_o, taken_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  branch_control #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .breq_o(breq_o), .brlt_o(brlt_o), .brltu_o(brltu_o),
    .is_branch_o(is_branch_o), .taken_o(taken_o), .taken_q_o(taken_q_o),
    .illegal_q_o(illegal_q_o)
`ifdef BRANCH_STATS_EN
    , .branch_cnt_o(branch_cnt_o), .taken_cnt_o(taken_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: compare as 64-bit integers, decide from the RV32I branch table.
  task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, output logic eq, output logic lt, output logic ltu,
                       output logic br, output logic tk, output logic ill);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    eq  = (ua == ub);
    lt  = (sa < sb);
    ltu = (ua < ub);
    br  = (op == 7'h63);
    tk  = 1'b0;
    ill = 1'b0;
    if (br) begin
      case (f3)
        3'd0: tk = eq;
        3'd1: tk = !eq;
        3'd4: tk = lt;
        3'd5: tk = !lt;
        3'd6: tk = ltu;
        3'd7: tk = !ltu;
        default: ill = 1'b1;
      endcase
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b);
    opcode_i = op;
    funct3_i = f3;
    rs1_i = a;
    rs2_i = b;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] sweep_a [16];
  logic [31:0] sweep_b [16];
  logic        sweep_eq [16];
  logic        sweep_lt [16];
  logic [2:0]  dec_f3 [7];
  logic        dec_tk [7];

  initial begin
    logic eq, lt, ltu, br, tk, ill;
    logic exp_tk_q, exp_ill_q;

    sweep_a = '{32'd5, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd10, -32'sd5, -32'sd10, 32'hFFFFFFFF,
                32'h80000000, 32'd50, 32'd3, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    sweep_b = '{32'd5, 32'd0, 32'hFFFFFFFF, 32'd2, 32'd100, 32'd3, -32'sd2, 32'd0,
                32'd0, 32'd10, -32'sd5, -32'sd20, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0};
    sweep_eq = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    sweep_lt = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    dec_f3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
    dec_tk = '{0, 1, 1, 0, 0, 1, 0};

    // Reset state
    #12;
    check("reset_taken_q", {31'd0, taken_q_o}, 32'd0);
    check("reset_illegal_q", {31'd0, illegal_q_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Comparator sweep, opcode=0 (first 14 entries are the listed pairs)
    for (int i = 0; i < 14; i++) begin
      drive(7'd0, 3'd0, sweep_a[i], sweep_b[i]);
      #1;
      check($sformatf("sweep%0d_breq", i), {31'd0, breq_o}, {31'd0, sweep_eq[i]});
      check($sformatf("sweep%0d_brlt", i), {31'd0, brlt_o}, {31'd0, sweep_lt[i]});
      check($sformatf("sweep%0d_isbr", i), {31'd0, is_branch_o}, 32'd0);
      check($sformatf("sweep%0d_taken", i), {31'd0, taken_o}, 32'd0);
    end

    // Unsigned vs signed
    drive(7'd0, 3'd0, 32'd0, 32'hFFFFFFFF);
    #1;
    check("uns_0_ffff_brltu", {31'd0, brltu_o}, 32'd1);
    check("uns_0_ffff_brlt", {31'd0, brlt_o}, 32'd0);
    drive(7'd0, 3'd0, 32'h80000000, 32'd1);
    #1;
    check("uns_8000_1_brltu", {31'd0, brltu_o}, 32'd0);
    check("uns_8000_1_brlt", {31'd0, brlt_o}, 32'd1);

    // Decision table with rs1=-1, rs2=0
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      drive(7'b1100011, dec_f3[i], 32'hFFFFFFFF, 32'd0);
      #1;
      check($sformatf("dec_f3_%0b_taken", dec_f3[i]), {31'd0, taken_o}, {31'd0, dec_tk[i]});
    end
    @(posedge clk_i);
    #1;
    check("illegal_q_after_010", {31'd0, illegal_q_o}, 32'd1);
    check("taken_q_after_010", {31'd0, taken_q_o}, 32'd0);

    // Register timing: taken rises between edges, visible only after next edge
    @(negedge clk_i);
    drive(7'b1100011, 3'b000, 32'd1, 32'd2);
    @(posedge clk_i);
    #1;
    check("timing_q_low", {31'd0, taken_q_o}, 32'd0);
    check("timing_illegal_cleared", {31'd0, illegal_q_o}, 32'd0);
    @(negedge clk_i);
    drive(7'b1100011, 3'b001, 32'd1, 32'd2);
    #1;
    check("timing_taken_comb", {31'd0, taken_o}, 32'd1);
    check("timing_q_not_before", {31'd0, taken_q_o}, 32'd0);
    @(posedge clk_i);
    #1;
    check("timing_q_after", {31'd0, taken_q_o}, 32'd1);

    // Asynchronous reset mid-cycle, held across an edge, then recapture
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_taken_q", {31'd0, taken_q_o}, 32'd0);
    check("async_rst_illegal_q", {31'd0, illegal_q_o}, 32'd0);
    check("async_rst_comb_taken", {31'd0, taken_o}, 32'd1);
    @(posedge clk_i);
    #1;
    check("rst_held_taken_q", {31'd0, taken_q_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_release_recapture", {31'd0, taken_q_o}, 32'd1);

    // Randomized stimulus against the model
    for (int n = 0; n < 300; n++) begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] a, b;
      @(negedge clk_i);
      op = ($urandom_range(0, 3) != 0) ? 7'b1100011 : 7'($urandom);
      f3 = 3'($urandom);
      a  = rand_operand();
      b  = ($urandom_range(0, 3) == 0) ? a : rand_operand();
      drive(op, f3, a, b);
      model(op, f3, a, b, eq, lt, ltu, br, tk, ill);
      exp_tk_q  = tk;
      exp_ill_q = ill;
      #1;
      check("rnd_breq", {31'd0, breq_o}, {31'd0, eq});
      check("rnd_brlt", {31'd0, brlt_o}, {31'd0, lt});
      check("rnd_brltu", {31'd0, brltu_o}, {31'd0, ltu});
      check("rnd_isbr", {31'd0, is_branch_o}, {31'd0, br});
      check("rnd_taken", {31'd0, taken_o}, {31'd0, tk});
      @(posedge clk_i);
      #1;
      check("rnd_taken_q", {31'd0, taken_q_o}, {31'd0, exp_tk_q});
      check("rnd_illegal_q", {31'd0, illegal_q_o}, {31'd0, exp_ill_q});
    end

`ifdef BRANCH_STATS_EN
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("stats_rst_branch", branch_cnt_o, 32'd0);
    check("stats_rst_taken", taken_cnt_o, 32'd0);
    drive(7'b1100011, 3'b000, 32'd7, 32'd7);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    drive(7'b1100011, 3'b001, 32'd7, 32'd7);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    drive(7'd0, 3'd0, 32'd0, 32'd0);
    #1;
    check("stats_branch_cnt", branch_cnt_o, 32'd8);
    check("stats_taken_cnt", taken_cnt_o, 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
